bram_line_responder: RTL
========================

BRAM_LINE_RESPONDER -- requirements
Module: bram_line_responder

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the backing store depth to 2^ADDR_W 16-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0-15, SHALL set the wait states inserted between request acceptance and the first beat.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 mem_req  input  1  SHALL be the line request from the cache-side requester.
REQ-006 mem_wren  input  1  SHALL select a line write (1) or a line read (0); sampled with mem_req.
REQ-007 mem_address  input  24  SHALL be the word address; bits [1:0] and bits [23:ADDR_W] are ignored.
REQ-008 to_mem  input  16  SHALL be the write data, driven by the requester for the word selected by mem_offset.
REQ-009 from_mem  output  16  SHALL be the read data for the current beat.
REQ-010 mem_offset  output  2  SHALL be the word index within the line for the current beat.
REQ-011 mem_ready  output  1  SHALL be a per-beat strobe that qualifies mem_offset, from_mem and to_mem.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 The state machine SHALL have exactly four states: IDLE, WAIT, BURST and DONE.
REQ-014 In IDLE, mem_req high at an edge SHALL latch the line base (mem_address[ADDR_W-1:2]) and mem_wren.
REQ-015 On that edge, the next state SHALL be WAIT if WAIT_CYCLES>0, else BURST.
REQ-016 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to BURST.
REQ-017 BURST SHALL last exactly 4 consecutive cycles, with mem_ready=1 and mem_offset=0,1,2,3 in order.
REQ-018 If mem_req is first seen in IDLE in cycle N, the first mem_ready SHALL occur in cycle N+1+WAIT_CYCLES.
REQ-019 Read beat: from_mem SHALL equal mem[{base,mem_offset}] during each mem_ready cycle.
REQ-020 Read beat: the RAM read SHALL be issued one cycle ahead so that from_mem is registered.
REQ-021 Read beat: from_mem SHALL hold the last beat's value when mem_ready is low.
REQ-022 Write beat: at the end of each mem_ready cycle, to_mem SHALL be written to mem[{base,mem_offset}]; from_mem SHALL be unchanged.
REQ-023 After beat 3, the block SHALL spend one cycle in DONE with mem_ready=0, then return to IDLE.
REQ-024 mem_req SHALL be ignored in DONE; the requester deasserts mem_req in the cycle after its last beat.
REQ-025 A request held high in IDLE SHALL be accepted; back-to-back bursts SHALL be separated by at least DONE plus one IDLE cycle.
REQ-026 mem_req, mem_wren and mem_address changes after acceptance SHALL be ignored.
REQ-027 A burst, once accepted, SHALL always complete all 4 beats; mem_req dropping mid-burst does not abort it.
REQ-028 Beat addresses SHALL never cross a line boundary; the top line of memory SHALL be served without wrap.
REQ-029 Addresses at or above 2^ADDR_W SHALL alias modulo 2^ADDR_W.
REQ-030 mem_offset SHALL read 0 outside BURST.

Reset
REQ-031 rst high SHALL force, immediately and asynchronously: state=IDLE, mem_ready=0, mem_offset=0, from_mem=16'h0000, busy=0, wait counter=0.
REQ-032 Reset mid-burst SHALL abandon the burst; words already written SHALL remain.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 The first request SHALL be accepted at the first rising edge after rst falls, if mem_req is high at that edge.

Verification
REQ-035 WAIT_CYCLES=2: write line at address 0x000010 with data A0..A3, then read it back -> mem_ready in cycles N+3..N+6 each time; mem_offset 0..3; read data A0,A1,A2,A3.
REQ-036 WAIT_CYCLES=0: read request seen in cycle N -> mem_ready high exactly in cycles N+1..N+4; busy low again at N+6.
REQ-037 Write address 0x001FFC with ADDR_W=12 and data 1111..4444, then read address 0x000FFC -> same data returned (aliasing, top line, no wrap).
REQ-038 Drop mem_req after beat 1 and toggle mem_address mid-burst -> all 4 beats still complete to the originally latched line.
REQ-039 Assert rst during beat 2 of a write -> outputs reset immediately; a later read returns new data for offsets 0-1 and old data for offsets 2-3.
REQ-040 Hold mem_req high continuously -> bursts repeat, with mem_ready low for at least 2 cycles between bursts.

Source files
------------

// File: rtl/bram_line_responder.sv
// Line-oriented BRAM responder: accepts a 4-word line read or write request,
// inserts WAIT_CYCLES wait states, then serves four consecutive beats.
module bram_line_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_wren,
    input  logic [23:0] mem_address,
    input  logic [15:0] to_mem,
    output logic [15:0] from_mem,
    output logic [1:0]  mem_offset,
    output logic        mem_ready,
    output logic        busy
);

    localparam int         LINE_W    = ADDR_W - 2;
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    logic [15:0]       mem [DEPTH];
    state_t            state;
    logic [LINE_W-1:0] line_base;
    logic              line_wren;
    logic [3:0]        wait_cnt;
    logic [LINE_W-1:0] req_base;
    logic [1:0]        next_offset;
    logic              unused_addr_bits;

    assign req_base         = mem_address[ADDR_W-1:2];
    assign next_offset      = mem_offset + 2'd1;
    assign unused_addr_bits = ^{mem_address[23:ADDR_W], mem_address[1:0]};

    // Read data is fetched on the edge that enters each beat, so from_mem is
    // a registered RAM output that simply holds between read beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            line_base  <= '0;
            line_wren  <= 1'b0;
            wait_cnt   <= 4'd0;
            mem_ready  <= 1'b0;
            mem_offset <= 2'd0;
            from_mem   <= 16'h0000;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        line_base <= req_base;
                        line_wren <= mem_wren;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state      <= BURST;
                            mem_ready  <= 1'b1;
                            mem_offset <= 2'd0;
                            if (!mem_wren) begin
                                from_mem <= mem[{req_base, 2'b00}];
                            end
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state      <= BURST;
                        wait_cnt   <= 4'd0;
                        mem_ready  <= 1'b1;
                        mem_offset <= 2'd0;
                        if (!line_wren) begin
                            from_mem <= mem[{line_base, 2'b00}];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (mem_offset == 2'd3) begin
                        state      <= DONE;
                        mem_ready  <= 1'b0;
                        mem_offset <= 2'd0;
                    end else begin
                        mem_offset <= next_offset;
                        if (!line_wren) begin
                            from_mem <= mem[{line_base, next_offset}];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (state == BURST && line_wren) begin
            mem[{line_base, mem_offset}] <= to_mem;
        end
    end

endmodule
